prbs22_checker: RTL

Receive-side checker for the 22-bit PRBS word stream produced by the sanity-test LFSR. It regenerates the expected next word from its own state and compares it with each received word. It acquires and loses lock with hysteresis and keeps saturating word, error and lock-loss counters. It sits downstream of the LFSR in the DAC/modem loopback sanity path, on the same clock enable.

---
 rtl/prbs22_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/prbs22_checker.sv
`timescale 1ns/1ps
// Receive-side checker for the 22-bit PRBS word stream. Regenerates the expected
// word locally, locks/unlocks with hysteresis and keeps saturating statistics.
module prbs22_checker #(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int WINDOW      = 64,
  parameter int ERR_W       = 16,
  parameter int CNT_W       = 32
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clk_ena,
  input  logic [21:0]      data_in,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] word_count,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       lock_loss_count
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int WC_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [21:0]     ref_word;
  logic            ref_valid;
  logic [MC_W-1:0] match_cnt;
  logic [WC_W-1:0] win_cnt;
  logic [WE_W-1:0] win_errs;

  logic            vld_p0;
  logic [21:0]     exp_p0;
  logic            hit_p0;
  logic [MC_W-1:0] match_nxt;
  logic [WC_W-1:0] win_cnt_nxt;
  logic [WE_W-1:0] win_errs_nxt;
  logic            lock_acq;
  logic            lock_lost;
  logic            win_roll;

  // The two all-ones/all-zeros escapes keep the generator out of its lock-up state.
  function automatic logic [21:0] prbs_next(input logic [21:0] x);
    if (x == 22'h000001)      return 22'h3FFFFF;
    else if (x == 22'h3FFFFF) return 22'h000000;
    else                      return {~(x[1] ^ x[0]), x[21:1]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_word(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_loss(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // Stage p0: compare the accepted word against the locally regenerated one
  assign vld_p0 = clk_ena;

  always_comb begin
    exp_p0       = prbs_next(ref_word);
    hit_p0       = (data_in == exp_p0);
    match_nxt    = (ref_valid && hit_p0) ? match_cnt + MC_W'(1) : '0;
    win_cnt_nxt  = win_cnt + WC_W'(1);
    win_errs_nxt = win_errs + WE_W'(!hit_p0);
    lock_acq     = vld_p0 && (state == HUNT) && (match_nxt == MC_W'(LOCK_COUNT));
    lock_lost    = vld_p0 && (state == LOCKED) && !hit_p0 &&
                   (win_errs_nxt == WE_W'(UNLOCK_ERRS));
    win_roll     = (win_cnt_nxt == WC_W'(WINDOW));
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (lock_acq)  state_nxt = LOCKED;
      LOCKED:  if (lock_lost) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // Stage p1: reference, hysteresis and window registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ref_word  <= '0;
      ref_valid <= 1'b0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_errs  <= '0;
      err_flag  <= 1'b0;
    end else begin
      err_flag <= 1'b0;
      if (vld_p0) begin
        if (state == HUNT) begin
          ref_word  <= data_in;
          ref_valid <= 1'b1;
          match_cnt <= match_nxt;
          if (lock_acq) begin
            win_cnt  <= '0;
            win_errs <= '0;
          end
        end else begin
          err_flag <= !hit_p0;
          if (lock_lost) begin
            ref_word  <= data_in;
            match_cnt <= '0;
          end else begin
            // Free-run on the regenerated word so one bad word costs exactly one error.
            ref_word <= exp_p0;
            if (win_roll) begin
              win_cnt  <= '0;
              win_errs <= '0;
            end else begin
              win_cnt  <= win_cnt_nxt;
              win_errs <= win_errs_nxt;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      word_count      <= '0;
      err_count       <= '0;
      lock_loss_count <= '0;
    end else if (clear_counts) begin
      word_count      <= '0;
      err_count       <= '0;
      lock_loss_count <= '0;
    end else if (vld_p0 && (state == LOCKED)) begin
      word_count <= sat_inc_word(word_count);
      if (!hit_p0)   err_count       <= sat_inc_err(err_count);
      if (lock_lost) lock_loss_count <= sat_inc_loss(lock_loss_count);
    end
  end

endmodule
